// File: rtl/fifo_read_ctrl.sv
// Read-side drain controller for the dual-clock FIFO: issues read strobes, captures
// 1-cycle-latency read data into a 2-entry skid buffer and streams it out over valid/ready.
module fifo_read_ctrl #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 16
) (
    input  logic             r_clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             e_flag,
    input  logic [SIZE-1:0]  fifo_data,
    output logic             rd_en,
    output logic [SIZE-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] word_count,
    output logic [SIZE-1:0]  checksum,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rd_pending;
    logic [1:0]      occ;
    logic [SIZE-1:0] buf_mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic            pop;
    logic            capture;
    logic [2:0]      fill_after;

    // Stream handshake: a word transfers on every cycle where out_valid & out_ready;
    // out_valid never drops and out_data never changes until that transfer happens.
    assign pop     = out_valid & out_ready;
    assign capture = rd_pending;

    // Fill the buffer will have once this cycle's capture and pop settle; a new read
    // is safe only while that leaves room for the word it brings back.
    assign fill_after = {1'b0, occ} + {2'b00, rd_pending} - {2'b00, pop};

    always_comb begin
        rd_en = (state == RUN) & enable & ~e_flag & (fill_after < 3'd2);
    end

    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (!enable) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (!rd_pending && occ == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_pending <= 1'b0;
            occ        <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            rd_pending <= rd_en;
            if (capture) begin
                buf_mem[wr_ptr] <= fifo_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= fill_after[1:0];
        end
    end

    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            word_count <= '0;
            checksum   <= '0;
        end else if (pop) begin
            word_count <= word_count + 1'b1;
            checksum   <= checksum + out_data;
        end
    end

    assign out_valid = (occ != 2'd0);
    assign out_data  = buf_mem[rd_ptr];
    assign busy      = rd_pending | (occ != 2'd0);
    assign dbg_state = state;

    // A capture into a full buffer with no pop would overwrite the head word.
    a_no_overflow: assert property (@(posedge r_clk) disable iff (!n_rst)
        !(capture && occ == 2'd2 && !pop));

    a_no_read_when_empty: assert property (@(posedge r_clk) disable iff (!n_rst)
        !(rd_en && e_flag));

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: FIFO model with 1-cycle read latency, expected-word queue
// filled at preload time and drained by an independent output monitor.
module tb_fifo_read_ctrl;
    localparam int SIZE  = 8;
    localparam int CNT_W = 16;
    localparam int MEM_D = 131072;

    logic             r_clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             enable = 1'b0;
    logic             e_flag;
    logic [SIZE-1:0]  fifo_data = '0;
    logic             rd_en;
    logic [SIZE-1:0]  out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] word_count;
    logic [SIZE-1:0]  checksum;
    logic [1:0]       dbg_state;

    fifo_read_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .r_clk(r_clk), .n_rst(n_rst), .enable(enable), .e_flag(e_flag),
        .fifo_data(fifo_data), .rd_en(rd_en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .word_count(word_count), .checksum(checksum), .dbg_state(dbg_state)
    );

    always #5 r_clk = ~r_clk;

    // FIFO model: data appears on fifo_data the cycle after a read strobe.
    logic [SIZE-1:0] fifo_mem [MEM_D];
    int fifo_rd = 0;
    int fifo_wr = 0;
    assign e_flag = (fifo_rd == fifo_wr);

    always @(posedge r_clk) begin
        if (rd_en) begin
            fifo_data <= fifo_mem[fifo_rd];
            fifo_rd   <= fifo_rd + 1;
        end
    end

    // Scoreboard state
    logic [SIZE-1:0]  exp_q[$];
    logic [SIZE-1:0]  exp_word;
    logic [CNT_W-1:0] exp_count = '0;
    logic [SIZE-1:0]  exp_sum = '0;
    int n_compared = 0;
    int n_mismatched = 0;
    int n_delivered = 0;
    logic stall_prev = 1'b0;
    logic [SIZE-1:0] data_prev = '0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_word(input logic [SIZE-1:0] d);
        fifo_mem[fifo_wr] = d;
        fifo_wr++;
        exp_q.push_back(d);
    endtask

    // Monitor
    always @(negedge r_clk) begin
        if (n_rst) begin
            if (e_flag) check("rd_en_while_empty", {63'd0, rd_en}, 64'd0);
            if (stall_prev) check("stall_hold", {55'd0, out_valid, out_data}, {55'd0, 1'b1, data_prev});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL unexpected_word: got %0d, expected no word", out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("out_data", {56'd0, out_data}, {56'd0, exp_word});
                    exp_count = exp_count + 1'b1;
                    exp_sum   = exp_sum + exp_word;
                    n_delivered++;
                end
            end
            stall_prev = out_valid & ~out_ready;
            data_prev  = out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic wait_drain(input int max_cyc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge r_clk);
            if (e_flag && !busy && exp_q.size() == 0) done = 1'b1;
        end
        check("drain_done", {63'd0, done}, 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_en"}, {63'd0, rd_en}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_out_data"}, {56'd0, out_data}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_word_count"}, {48'd0, word_count}, 64'd0);
        check({tag, "_checksum"}, {56'd0, checksum}, 64'd0);
        check({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
    endtask

    int rd_cnt, pop_cnt, first_rd, last_rd, first_pop, last_pop;
    int pop_i, busy_low_i, drop_n;
    logic seen_flush, found;

    initial begin
        // Reset
        repeat (3) @(posedge r_clk);
        @(negedge r_clk);
        check_reset_values("reset");
        @(posedge r_clk); #1;
        n_rst = 1'b1; enable = 1'b1; out_ready = 1'b1;

        // Enabled but FIFO empty: no reads
        rd_cnt = 0;
        repeat (10) begin
            @(negedge r_clk);
            if (rd_en) rd_cnt++;
        end
        check("empty_rd_cnt", rd_cnt, 0);
        check("empty_out_valid", {63'd0, out_valid}, 64'd0);
        check("empty_busy", {63'd0, busy}, 64'd0);
        check("empty_state_run", {62'd0, dbg_state}, 64'd1);

        // Full-throughput burst
        @(posedge r_clk); #1;
        push_word(8'd21); push_word(8'd247); push_word(8'd90); push_word(8'd10);
        rd_cnt = 0; pop_cnt = 0; first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge r_clk);
            if (rd_en) begin
                if (first_rd < 0) first_rd = i;
                last_rd = i;
                rd_cnt++;
            end
            if (out_valid && out_ready) begin
                if (first_pop < 0) first_pop = i;
                last_pop = i;
                pop_cnt++;
            end
        end
        check("burst_rd_cnt", rd_cnt, 4);
        check("burst_first_rd", first_rd, 0);
        check("burst_last_rd", last_rd, 3);
        check("burst_pop_cnt", pop_cnt, 4);
        check("burst_first_pop", first_pop, 2);
        check("burst_last_pop", last_pop, 5);
        check("burst_word_count", {48'd0, word_count}, 64'd4);
        check("burst_checksum", {56'd0, checksum}, 64'd112);

        // Consumer stall
        @(posedge r_clk); #1;
        out_ready = 1'b0;
        push_word(8'd21); push_word(8'd247); push_word(8'd90); push_word(8'd10);
        rd_cnt = 0;
        repeat (10) begin
            @(negedge r_clk);
            if (rd_en) rd_cnt++;
        end
        check("stall_rd_cnt", rd_cnt, 2);
        check("stall_out_valid", {63'd0, out_valid}, 64'd1);
        check("stall_out_data", {56'd0, out_data}, 64'd21);
        check("stall_busy", {63'd0, busy}, 64'd1);
        @(posedge r_clk); #1;
        out_ready = 1'b1;
        wait_drain(50);
        check("stall_word_count", {48'd0, word_count}, 64'd8);
        check("stall_checksum", {56'd0, checksum}, 64'd224);

        // enable dropped right after the first read
        @(posedge r_clk); #1;
        enable = 1'b0;
        repeat (4) @(posedge r_clk);
        @(negedge r_clk);
        check("disable_state_idle", {62'd0, dbg_state}, 64'd0);
        @(posedge r_clk); #1;
        for (int d = 0; d <= 8; d++) push_word(8'(d));
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge r_clk);
            if (rd_en) found = 1'b1;
        end
        check("flush_first_rd", {63'd0, found}, 64'd1);
        @(posedge r_clk); #1;
        enable = 1'b0;
        rd_cnt = 0; seen_flush = 1'b0; pop_i = -1; busy_low_i = -1;
        for (int i = 0; i < 15; i++) begin
            @(negedge r_clk);
            if (rd_en) rd_cnt++;
            if (dbg_state == 2'd2) seen_flush = 1'b1;
            if (out_valid && out_ready && pop_i < 0) pop_i = i;
            if (!busy && busy_low_i < 0) busy_low_i = i;
        end
        check("flush_no_more_rd", rd_cnt, 0);
        check("flush_seen", {63'd0, seen_flush}, 64'd1);
        check("flush_pop_cycle", pop_i, 1);
        check("flush_busy_fall", busy_low_i, 2);
        check("flush_state_idle", {62'd0, dbg_state}, 64'd0);
        check("flush_word_count", {48'd0, word_count}, 64'd9);
        check("flush_checksum", {56'd0, checksum}, 64'd224);

        // Reset while the buffer is full
        @(posedge r_clk); #1;
        out_ready = 1'b0;
        enable = 1'b1;
        repeat (6) @(posedge r_clk);
        #3;
        check("prereset_valid", {63'd0, out_valid}, 64'd1);
        check("prereset_data", {56'd0, out_data}, 64'd1);
        n_rst = 1'b0;
        #1;
        check_reset_values("midreset");
        drop_n = fifo_rd - n_delivered;
        check("midreset_drop_n", drop_n, 2);
        repeat (drop_n) exp_q.pop_front();
        exp_count = '0;
        exp_sum = '0;
        @(posedge r_clk); #1;
        n_rst = 1'b1;
        out_ready = 1'b1;
        wait_drain(60);
        check("after_reset_word_count", {48'd0, word_count}, 64'd6);
        check("after_reset_checksum", {56'd0, checksum}, 64'd33);

        // Long stream: word_count wraps
        @(posedge r_clk); #3;
        n_rst = 1'b0;
        exp_count = '0;
        exp_sum = '0;
        @(posedge r_clk); #1;
        n_rst = 1'b1;
        for (int i = 0; i < 65537; i++) push_word(8'((i * 7 + 3) & 255));
        wait_drain(70000);
        check("stream_word_count", {48'd0, word_count}, 64'd1);
        check("stream_word_count_model", {48'd0, word_count}, {48'd0, exp_count});
        check("stream_checksum", {56'd0, checksum}, {56'd0, exp_sum});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
